goertzel_seq_ctrl: RTL

Sequencer and result collector for the fixed-bin Goertzel IIR datapath. It turns a raw sample strobe into decimated clock-enable pulses and issues the datapath's flush/reset at block start. It captures each block's Re/Im result into a 2-entry buffer with a valid/ready output handshake. It sits between the ADC sample front end and the downstream tone-decision logic, and owns the start/stop sequencing of the filter.

---
 rtl/goertzel_pkg.sv | 22 ++
 rtl/goertzel_res_fifo.sv | 59 +++++
 rtl/goertzel_seq_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/goertzel_pkg.sv
// Shared types and default widths for the Goertzel sequencer / result collector.
package goertzel_pkg;

    localparam int IW = 12;
    localparam int OW = 32;
    localparam int BW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic [OW-1:0] re;
        logic [OW-1:0] im;
        logic [BW-1:0] blk;
        logic          det;
    } res_entry_t;

endpackage

// File: rtl/goertzel_res_fifo.sv
// Two-deep first-word-fall-through FIFO; a pop frees a slot for a push in the same cycle.
module goertzel_res_fifo #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic [W-1:0] mem_q [2];
    logic [1:0]   count_q, count_d;
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic         push_ok, pop_ok;

    assign o_valid = (count_q != 2'd0);
    assign o_full  = (count_q == 2'd2);
    assign pop_ok  = i_pop & o_valid;
    assign push_ok = i_push & (~o_full | pop_ok);
    assign o_data  = o_valid ? mem_q[rd_q] : '0;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (push_ok) wr_d = ~wr_q;
        if (pop_ok)  rd_d = ~rd_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= 2'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // NOTE: storage is not reset; o_data is masked by o_valid so stale contents never leak.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_q] <= i_data;
    end

endmodule

// File: rtl/goertzel_seq_ctrl.sv
// Goertzel sequencer: decimated clock enables, flush at block start, Re/Im result buffering.
// Define GOERTZEL_SEQ_DETECT_EN to add the magnitude-squared tone-detect pipeline stage.
module goertzel_seq_ctrl
    import goertzel_pkg::*;
#(
    parameter int IW    = goertzel_pkg::IW,
    parameter int OW    = goertzel_pkg::OW,
    parameter int DECIM = 8,
    parameter int BW    = goertzel_pkg::BW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_sample_stb,
    output logic          o_core_clken,
    output logic          o_core_rst,
    input  logic          i_core_valid,
    input  logic [OW-1:0] i_core_re,
    input  logic [OW-1:0] i_core_im,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [OW-1:0] o_res_re,
    output logic [OW-1:0] o_res_im,
    output logic [BW-1:0] o_res_blk,
    output logic          o_res_det,
    input  logic [2*OW:0] i_thresh,
    output logic          o_busy,
    output logic          o_overrun
);

    localparam int            CW       = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] DEC_LAST = CW'(DECIM - 1);
    localparam int            EW       = 2*OW + BW + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   dec_cnt_q, dec_cnt_d;
    logic [BW-1:0]   blk_q, blk_d;
    logic            core_valid_q;
    logic            overrun_q, overrun_d;
    logic            flush_entry, capture;
    logic            push, drop, pipe_busy;
    logic [EW-1:0]   push_data, fifo_dout;
    logic            fifo_full;
    logic [IW-1:0]   unused_iw;

    assign unused_iw = '0;

    always_comb begin
        state_d      = state_q;
        dec_cnt_d    = dec_cnt_q;
        o_core_clken = 1'b0;
        o_core_rst   = 1'b0;
        flush_entry  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = FLUSH;
                    flush_entry = 1'b1;
                end
            end
            FLUSH: begin
                o_core_rst   = 1'b1;
                o_core_clken = 1'b1;
                dec_cnt_d    = '0;
                state_d      = RUN;
            end
            RUN: begin
                // A stop discards the partial block, so it also suppresses a coincident enable.
                if (i_stop) begin
                    state_d = DRAIN;
                end else if (i_sample_stb) begin
                    if (dec_cnt_q == DEC_LAST) begin
                        o_core_clken = 1'b1;
                        dec_cnt_d    = '0;
                    end else begin
                        dec_cnt_d = dec_cnt_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!o_res_valid && !pipe_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign capture = i_core_valid & ~core_valid_q & ((state_q == RUN) | (state_q == DRAIN));
    assign drop    = push & fifo_full & ~(o_res_valid & i_res_ready);

    always_comb begin
        blk_d     = blk_q;
        overrun_d = overrun_q | drop;
        if (flush_entry) begin
            blk_d     = '0;
            overrun_d = 1'b0;
        end else if (capture) begin
            blk_d = blk_q + BW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            dec_cnt_q    <= '0;
            blk_q        <= '0;
            core_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dec_cnt_q    <= dec_cnt_d;
            blk_q        <= blk_d;
            core_valid_q <= i_core_valid;
            overrun_q    <= overrun_d;
        end
    end

`ifdef GOERTZEL_SEQ_DETECT_EN
    logic                   pipe_valid_q, pipe_valid_d;
    logic [OW-1:0]          pipe_re_q, pipe_re_d;
    logic [OW-1:0]          pipe_im_q, pipe_im_d;
    logic [BW-1:0]          pipe_blk_q, pipe_blk_d;
    logic signed [2*OW-1:0] re_sq, im_sq;
    logic [2*OW:0]          mag2;

    always_comb begin
        pipe_valid_d = capture;
        pipe_re_d    = pipe_re_q;
        pipe_im_d    = pipe_im_q;
        pipe_blk_d   = pipe_blk_q;
        if (capture) begin
            pipe_re_d  = i_core_re;
            pipe_im_d  = i_core_im;
            pipe_blk_d = blk_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_valid_q <= 1'b0;
            pipe_re_q    <= '0;
            pipe_im_q    <= '0;
            pipe_blk_q   <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_re_q    <= pipe_re_d;
            pipe_im_q    <= pipe_im_d;
            pipe_blk_q   <= pipe_blk_d;
        end
    end

    // Squares of signed values are non-negative, so zero-extending each before the add is exact.
    assign re_sq     = $signed(pipe_re_q) * $signed(pipe_re_q);
    assign im_sq     = $signed(pipe_im_q) * $signed(pipe_im_q);
    assign mag2      = {1'b0, re_sq} + {1'b0, im_sq};
    assign push      = pipe_valid_q;
    assign pipe_busy = pipe_valid_q;
    assign push_data = {pipe_re_q, pipe_im_q, pipe_blk_q, (mag2 >= i_thresh)};
`else
    logic unused_thresh;

    assign unused_thresh = ^i_thresh;
    assign push          = capture;
    assign pipe_busy     = 1'b0;
    assign push_data     = {i_core_re, i_core_im, blk_q, 1'b0};
`endif

    goertzel_res_fifo #(
        .W (EW)
    ) u_res_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (push_data),
        .i_pop   (i_res_ready),
        .o_valid (o_res_valid),
        .o_full  (fifo_full),
        .o_data  (fifo_dout)
    );

    assign {o_res_re, o_res_im, o_res_blk, o_res_det} = fifo_dout;
    assign o_busy    = (state_q != IDLE);
    assign o_overrun = overrun_q;

endmodule
